// File: rtl/hazard_pkg.sv
// Shared pipeline definitions for the decode-stage hazard unit: FSM encoding,
// default register address width and the NOP pattern injected as a bubble.
package hazard_pkg;

  localparam int REG_AW_DEF = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } hz_state_e;

  // addi x0, x0, 0 -- what the ID/EX register carries while bubble_idex is high
  localparam logic [31:0] NOP_BUBBLE = 32'h0000_0013;

endpackage

// File: rtl/hazard_cmp.sv
// Source/destination comparator for one writer stage: flags a read of rd by
// the IF/ID instruction when that stage actually writes rd.
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_use,
  input  logic              rs2_use,
  input  logic [REG_AW-1:0] rd,
  input  logic              en,
  output logic              match
);

  logic rd_live;

  // A hardwired-zero destination never carries a value worth waiting for
  assign rd_live = en && !(ZERO_REG && (rd == '0));
  assign match   = rd_live && ((rs1_use && (rs1 == rd)) || (rs2_use && (rs2 == rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard unit: load-use stall sequencer, optional full-RAW stall,
// branch flush and a saturating count of stalled cycles.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW            = REG_AW_DEF,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter bit FWD_EN            = 1'b1,
  parameter bit ZERO_REG          = 1'b0,
  parameter int CNT_W             = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_ifid,
  input  logic [REG_AW-1:0] rs2_ifid,
  input  logic              rs1_use_ifid,
  input  logic              rs2_use_ifid,
  input  logic [REG_AW-1:0] rd_idex,
  input  logic              regwrite_idex,
  input  logic              memread_idex,
  input  logic [REG_AW-1:0] rd_exmem,
  input  logic              regwrite_exmem,
  input  logic              branch_taken_exmem,
  output logic              stall_ctrl,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  localparam logic [2:0]       REMAIN_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  // Writer stages: index 0 = ID/EX, index 1 = EX/MEM
  logic [REG_AW-1:0] wr_rd    [2];
  logic              wr_en    [2];
  logic              wr_match [2];

  assign wr_rd[0] = rd_idex;
  assign wr_rd[1] = rd_exmem;
  assign wr_en[0] = regwrite_idex;
  assign wr_en[1] = regwrite_exmem;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cmp
      hazard_cmp #(
        .REG_AW   (REG_AW),
        .ZERO_REG (ZERO_REG)
      ) u_cmp (
        .rs1     (rs1_ifid),
        .rs2     (rs2_ifid),
        .rs1_use (rs1_use_ifid),
        .rs2_use (rs2_use_ifid),
        .rd      (wr_rd[gi]),
        .en      (wr_en[gi]),
        .match   (wr_match[gi])
      );
    end
  endgenerate

  logic lu_hit;
  logic raw_hit;
  logic flush;

  assign lu_hit  = memread_idex && wr_match[0];
  // Without forwarding any pending writer blocks decode until it drains
  assign raw_hit = FWD_EN ? 1'b0 : (wr_match[0] || wr_match[1]);

  hz_state_e  state_reg, state_next;
  logic [2:0] remain_reg, remain_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      remain_reg <= 3'd0;
    end else begin
      state_reg  <= state_next;
      remain_reg <= remain_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
    stall_ctrl  = 1'b0;
    flush       = 1'b0;
    if (branch_taken_exmem) begin
      // Wrong-path instructions are discarded, so any stall in progress is moot
      flush       = 1'b1;
      state_next  = IDLE;
      remain_next = 3'd0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (lu_hit && (LOAD_STALL_CYCLES > 1)) begin
            state_next  = LU_STALL;
            remain_next = REMAIN_INIT;
          end
        end
        LU_STALL: begin
          remain_next = remain_reg - 3'd1;
          if (remain_reg == 3'd1) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
      stall_ctrl = (state_reg == LU_STALL) || lu_hit || raw_hit;
    end
    if (rst) begin
      stall_ctrl = 1'b0;
      flush      = 1'b0;
    end
  end

  assign bubble_idex = stall_ctrl;
  assign flush_ifid  = flush;
  assign flush_idex  = flush;

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr_cnt) begin
      cnt_reg <= '0;
    end else if (stall_ctrl && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three configurations share one stimulus stream and
// are checked every cycle against a remaining-stall-cycles model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rs1_ifid, rs2_ifid, rd_idex, rd_exmem;
  logic       rs1_use_ifid, rs2_use_ifid;
  logic       regwrite_idex, memread_idex, regwrite_exmem;
  logic       branch_taken_exmem, clr_cnt;

  logic [2:0]  stall_o, bub_o, fi_o, fx_o;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  always #5 clk = ~clk;

  // Instance configurations: LOAD_STALL_CYCLES, FWD_EN, ZERO_REG, CNT_W
  int cfg_lsc [3] = '{1, 3, 1};
  int cfg_fwd [3] = '{1, 1, 0};
  int cfg_zr  [3] = '{0, 1, 0};
  int cfg_cw  [3] = '{16, 16, 2};

  hazard_ctrl #(.REG_AW(3), .LOAD_STALL_CYCLES(1), .FWD_EN(1'b1), .ZERO_REG(1'b0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
    .rs1_use_ifid(rs1_use_ifid), .rs2_use_ifid(rs2_use_ifid),
    .rd_idex(rd_idex), .regwrite_idex(regwrite_idex), .memread_idex(memread_idex),
    .rd_exmem(rd_exmem), .regwrite_exmem(regwrite_exmem), .branch_taken_exmem(branch_taken_exmem),
    .stall_ctrl(stall_o[0]), .bubble_idex(bub_o[0]), .flush_ifid(fi_o[0]), .flush_idex(fx_o[0]),
    .stall_cnt(cnt_a), .clr_cnt(clr_cnt));

  hazard_ctrl #(.REG_AW(3), .LOAD_STALL_CYCLES(3), .FWD_EN(1'b1), .ZERO_REG(1'b1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
    .rs1_use_ifid(rs1_use_ifid), .rs2_use_ifid(rs2_use_ifid),
    .rd_idex(rd_idex), .regwrite_idex(regwrite_idex), .memread_idex(memread_idex),
    .rd_exmem(rd_exmem), .regwrite_exmem(regwrite_exmem), .branch_taken_exmem(branch_taken_exmem),
    .stall_ctrl(stall_o[1]), .bubble_idex(bub_o[1]), .flush_ifid(fi_o[1]), .flush_idex(fx_o[1]),
    .stall_cnt(cnt_b), .clr_cnt(clr_cnt));

  hazard_ctrl #(.REG_AW(3), .LOAD_STALL_CYCLES(1), .FWD_EN(1'b0), .ZERO_REG(1'b0), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
    .rs1_use_ifid(rs1_use_ifid), .rs2_use_ifid(rs2_use_ifid),
    .rd_idex(rd_idex), .regwrite_idex(regwrite_idex), .memread_idex(memread_idex),
    .rd_exmem(rd_exmem), .regwrite_exmem(regwrite_exmem), .branch_taken_exmem(branch_taken_exmem),
    .stall_ctrl(stall_o[2]), .bubble_idex(bub_o[2]), .flush_ifid(fi_o[2]), .flush_idex(fx_o[2]),
    .stall_cnt(cnt_c), .clr_cnt(clr_cnt));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: stall cycles still owed after the current one, plus the counter
  int m_left [3];
  int m_cnt  [3];

  function automatic bit reads(int i, logic [2:0] rd);
    if (cfg_zr[i] != 0 && rd == 3'd0) return 1'b0;
    return (rs1_use_ifid && rs1_ifid == rd) || (rs2_use_ifid && rs2_ifid == rd);
  endfunction

  function automatic bit exp_stall(int i);
    bit lu, raw;
    lu  = memread_idex && regwrite_idex && reads(i, rd_idex);
    raw = (cfg_fwd[i] == 0) &&
          ((regwrite_idex && reads(i, rd_idex)) || (regwrite_exmem && reads(i, rd_exmem)));
    return !rst && !branch_taken_exmem && (m_left[i] > 0 || lu || raw);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_left[i] = 0;
        m_cnt[i]  = 0;
      end else begin
        bit s;
        bit lu;
        s  = exp_stall(i);
        lu = memread_idex && regwrite_idex && reads(i, rd_idex);
        if (clr_cnt) m_cnt[i] = 0;
        else if (s && m_cnt[i] < (1 << cfg_cw[i]) - 1) m_cnt[i] = m_cnt[i] + 1;
        if (branch_taken_exmem) m_left[i] = 0;
        else if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
        else if (lu) m_left[i] = cfg_lsc[i] - 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int act_cnt;
      bit fl;
      act_cnt = (i == 0) ? int'(cnt_a) : (i == 1) ? int'(cnt_b) : int'(cnt_c);
      fl = !rst && branch_taken_exmem;
      chk($sformatf("stall_ctrl[%0d]", i), int'(stall_o[i]), int'(exp_stall(i)));
      chk($sformatf("bubble_idex[%0d]", i), int'(bub_o[i]), int'(exp_stall(i)));
      chk($sformatf("flush_ifid[%0d]", i), int'(fi_o[i]), int'(fl));
      chk($sformatf("flush_idex[%0d]", i), int'(fx_o[i]), int'(fl));
      chk($sformatf("stall_cnt[%0d]", i), act_cnt, m_cnt[i]);
    end
  end

  task automatic idle_in();
    rs1_ifid = 0; rs2_ifid = 0; rd_idex = 0; rd_exmem = 0;
    rs1_use_ifid = 0; rs2_use_ifid = 0;
    regwrite_idex = 0; memread_idex = 0; regwrite_exmem = 0;
    branch_taken_exmem = 0; clr_cnt = 0;
  endtask

  task automatic load_rs1_3();
    idle_in();
    memread_idex = 1; regwrite_idex = 1; rd_idex = 3; rs1_ifid = 3; rs1_use_ifid = 1;
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    idle_in(); clr_cnt = 1; hold(1); clr_cnt = 0;
  endtask

  initial begin
    idle_in();
    rst = 1;
    @(negedge clk);
    chk("reset stall_cnt b", int'(cnt_b), 0);
    chk("reset stall_ctrl b", int'(stall_o[1]), 0);
    hold(2);
    rst = 0;

    // Load-use, one cycle of request
    load_rs1_3(); hold(1);
    idle_in(); hold(4);
    chk("lu cnt a (1 cyc)", int'(cnt_a), 1);
    chk("lu cnt b (3 cyc)", int'(cnt_b), 3);
    chk("lu cnt c", int'(cnt_c), 1);

    // Branch on the second stall cycle of the 3-cycle instance
    clear_counts();
    load_rs1_3(); hold(1);
    idle_in(); branch_taken_exmem = 1;
    @(negedge clk); #1;
    chk("branch stall b", int'(stall_o[1]), 0);
    chk("branch flush_ifid b", int'(fi_o[1]), 1);
    @(posedge clk); #1;
    idle_in(); hold(3);
    chk("branch cnt b", int'(cnt_b), 1);

    // rd=0 load: hardwired-zero instance ignores it
    clear_counts();
    idle_in(); memread_idex = 1; regwrite_idex = 1; rd_idex = 0; rs2_ifid = 0; rs2_use_ifid = 1;
    hold(1);
    idle_in(); hold(3);
    chk("zero-reg cnt a", int'(cnt_a), 1);
    chk("zero-reg cnt b", int'(cnt_b), 0);
    chk("zero-reg cnt c", int'(cnt_c), 1);

    // EX/MEM RAW without forwarding, 5 cycles -> 2-bit counter saturates
    clear_counts();
    idle_in(); regwrite_exmem = 1; rd_exmem = 5; rs2_ifid = 5; rs2_use_ifid = 1;
    hold(5);
    idle_in(); hold(2);
    chk("raw cnt c sat", int'(cnt_c), 3);
    chk("raw cnt a", int'(cnt_a), 0);
    clear_counts();
    hold(1);
    chk("clr cnt c", int'(cnt_c), 0);

    // Reset in the middle of LU_STALL
    load_rs1_3(); hold(1);
    idle_in(); rst = 1;
    @(negedge clk); #1;
    chk("rst mid-stall stall b", int'(stall_o[1]), 0);
    chk("rst mid-stall cnt b", int'(cnt_b), 0);
    @(posedge clk); #1;
    rst = 0; hold(3);
    chk("post-rst cnt b", int'(cnt_b), 0);

    // Back-to-back loads: new hit as the sequence ends restarts it
    load_rs1_3(); hold(4);
    idle_in(); hold(4);
    chk("b2b cnt b", int'(cnt_b), 6);
    chk("b2b cnt a", int'(cnt_a), 4);

    // Mixed vectors with small register numbers to provoke hits
    for (int k = 0; k < 60; k++) begin
      rs1_ifid = 3'($urandom_range(0, 3)); rs2_ifid = 3'($urandom_range(0, 3));
      rd_idex = 3'($urandom_range(0, 3)); rd_exmem = 3'($urandom_range(0, 3));
      rs1_use_ifid = 1'($urandom_range(0, 1)); rs2_use_ifid = 1'($urandom_range(0, 1));
      regwrite_idex = 1'($urandom_range(0, 1)); memread_idex = 1'($urandom_range(0, 1));
      regwrite_exmem = 1'($urandom_range(0, 1));
      branch_taken_exmem = ($urandom_range(0, 9) == 0);
      clr_cnt = ($urandom_range(0, 14) == 0);
      hold(1);
    end
    idle_in(); hold(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised hazard detection and pipeline-control unit for the 5-stage core, the successor to the single-cycle load-use detector. Compares IF/ID source registers against ID/EX and EX/MEM destinations and generates PC/IF-ID hold, ID/EX bubble and branch flush controls. Adds a multi-cycle load-use stall sequencer, a no-forwarding mode, a hardwired-zero-register option and a saturating stall-cycle counter. Sits in decode and drives the PC, IF/ID and ID/EX pipeline register enables and clears.

Parameters:
REG_AW, 3, register address width
LOAD_STALL_CYCLES, 1, total stall cycles per load-use hazard (1..7)
FWD_EN, 1, 1 = forwarding present (stall only on load-use); 0 = stall on any RAW against ID/EX or EX/MEM writer
ZERO_REG, 0, 1 = address 0 is hardwired zero and never creates a hazard
CNT_W, 16, width of stall_cnt performance counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rs1_ifid  in  REG_AW  source 1 address of instruction in IF/ID
rs2_ifid  in  REG_AW  source 2 address of instruction in IF/ID
rs1_use_ifid  in  1  instruction reads rs1
rs2_use_ifid  in  1  instruction reads rs2
rd_idex  in  REG_AW  destination in ID/EX
regwrite_idex  in  1  ID/EX writes rd
memread_idex  in  1  ID/EX is a load
rd_exmem  in  REG_AW  destination in EX/MEM
regwrite_exmem  in  1  EX/MEM writes rd
branch_taken_exmem  in  1  taken branch/jump resolved in EX/MEM
stall_ctrl  out  1  hold PC and IF/ID
bubble_idex  out  1  load NOP into ID/EX
flush_ifid  out  1  clear IF/ID
flush_idex  out  1  clear ID/EX
stall_cnt  out  CNT_W  saturating count of cycles with stall_ctrl=1
clr_cnt  in  1  synchronous clear of stall_cnt

Behaviour:
- Clock clk, reset rst: asynchronous and active-high. While rst=1: state IDLE, remain=0, stall_cnt=0; all control outputs 0 (combinational terms gated by rst).
- match_X(rd) = (rs1_use & rs1==rd) | (rs2_use & rs2==rd), excluding rd==0 when ZERO_REG=1.
- lu_hit = memread_idex & regwrite_idex & match(rd_idex).
- raw_hit (FWD_EN=0 only) = (regwrite_idex & match(rd_idex)) | (regwrite_exmem & match(rd_exmem)); purely combinational, re-evaluated each cycle as bubbles drain. Forced 0 when FWD_EN=1.
- State machine, states IDLE, LU_STALL; 3-bit counter remain.
  - IDLE: lu_hit -> stall_ctrl=1, bubble_idex=1 same cycle (zero latency). If LOAD_STALL_CYCLES>1: next state LU_STALL, remain=LOAD_STALL_CYCLES-1; else stay IDLE.
  - LU_STALL: stall_ctrl=1, bubble_idex=1 unconditionally (comparators ignored; ID/EX now holds a bubble). remain decrements each cycle; remain==1 -> next IDLE.
- stall_ctrl = (state==LU_STALL) | lu_hit | raw_hit; bubble_idex = stall_ctrl.
- Branch: branch_taken_exmem=1 -> flush_ifid=1, flush_idex=1 same cycle; stall_ctrl and bubble_idex forced 0 that cycle; state -> IDLE, remain -> 0 (flush aborts stall in progress). Branch has priority over every stall term.
- stall_cnt: +1 each cycle stall_ctrl=1; saturates at all-ones; clr_cnt=1 -> 0 next edge; clr_cnt wins over increment.
- Asserting rst mid-stall returns to IDLE immediately; no residual stall after release.
- Back-to-back loads: a new lu_hit in the cycle the machine returns to IDLE starts a fresh sequence.

Decomposition:
- Shared pipeline package: hazard state encoding (IDLE=0, LU_STALL=1), REG_AW default, NOP-bubble constant.
- One sub-module: hazard_cmp (rs1/rs2/use/rd/en -> match, honours ZERO_REG), instantiated once per writer stage.
- Counter and FSM stay in hazard_ctrl.

Test Plan:
- Load-use, LOAD_STALL_CYCLES=1: memread_idex=1, regwrite_idex=1, rd_idex=3, rs1_ifid=3, rs1_use=1 -> stall_ctrl=bubble_idex=1 for exactly 1 cycle; stall_cnt=1.
- LOAD_STALL_CYCLES=3, same stimulus, inputs deasserted after first cycle -> stall_ctrl high exactly 3 consecutive cycles, then 0; stall_cnt=3.
- Branch mid-stall (LOAD_STALL_CYCLES=3): branch_taken_exmem=1 on 2nd stall cycle -> flush_ifid=flush_idex=1, stall_ctrl=0 that cycle and after; state IDLE.
- ZERO_REG=1, rd_idex=0, rs2_ifid=0, rs2_use=1, load in ID/EX -> no stall; ZERO_REG=0 -> 1-cycle stall.
- FWD_EN=0: regwrite_exmem=1, rd_exmem=5, rs2_ifid=5, rs2_use=1, non-load -> stall_ctrl=1 while match holds; FWD_EN=1 same stimulus -> 0.
- Reset/counter: assert rst during LU_STALL -> all outputs 0 immediately, stall_cnt=0; CNT_W=2 with 5 stall cycles -> stall_cnt=3; clr_cnt=1 -> 0.
